usb_rx_packet: RTL
==================

Name: usb_rx_packet

Overview:
- Receive-side packet decoder downstream of the USB line proxy/sampler.
- Consumes one sampled line state per bit strobe (J/K/SE0) and performs SYNC detection, NRZI decode, bit-unstuffing, PID check, byte assembly and CRC5/CRC16 check.
- Emits a byte stream plus a per-packet status pulse for the sniffer/logging logic.

Parameters:
- MAX_BYTES, 1027: maximum number of bytes after the PID (payload plus CRC) before a length error.
- MIN_SYNC_ZEROS, 3: minimum decoded zeros before the SYNC-terminating 1. This tolerates hub-truncated SYNC.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- bit_strobe  input  1  one-cycle pulse per USB bit time; all line inputs are sampled only when this is high
- line_j  input  1  1 = J state, 0 = K state; ignored when line_se0 = 1
- line_se0  input  1  both data lines low
- out_data  output  8  assembled byte after the PID, CRC bytes included
- out_valid  output  1  one-cycle pulse, out_data valid
- pid  output  8  received PID byte in standard encoding (e.g. ACK = 8'hD2)
- pid_valid  output  1  one-cycle pulse
- pkt_done  output  1  one-cycle pulse at end of packet
- pkt_ok  output  1  valid with pkt_done; high when no error flag is set
- err_flags  output  5  {len, align, crc, stuff, pid}; valid with pkt_done
- byte_cnt  output  11  bytes after the PID; valid with pkt_done
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; the NRZI previous-level register is set to J.
- NRZI decode: bit = 1 when the current level equals the previous level, otherwise 0. The previous level updates on every non-SE0 strobe.
- Bit unstuffing:
  - A ones-run counter counts decoded 1s.
  - After six consecutive 1s, the next bit is a stuff bit. If it is 0, it is dropped. If it is 1, set stuff_err and go to ERR.
  - Applies in PID and DATA states only.
- Data is LSB-first. A byte completes on its 8th unstuffed bit. out_valid/pid_valid assert on the clk cycle after that strobe (one registered stage).
- States:
  - IDLE:
    - A strobe with a K level moves to SYNC and counts one zero.
    - SE0 or J keeps IDLE.
  - SYNC:
    - Each decoded 0 increments a zero counter (5-bit, saturating).
    - A decoded 1 with count >= MIN_SYNC_ZEROS moves to PID.
    - A decoded 1 with fewer zeros moves to IDLE.
    - SE0 moves to IDLE with no pkt_done.
  - PID:
    - After 8 bits, output pid and pulse pid_valid.
    - pid[3:0] != ~pid[7:4] sets pid_err; continue to DATA so that EOP is still tracked.
    - The CRC register is initialised here: CRC5 to 5'h1F, CRC16 to 16'hFFFF.
  - DATA:
    - Assemble and emit bytes; byte_cnt increments per byte.
    - When byte_cnt reaches MAX_BYTES: set len_err, stop emitting, and keep tracking until EOP.
    - A strobe with SE0 moves to EOP.
  - EOP:
    - A strobe with J moves to IDLE and pulses pkt_done with status.
    - A strobe with K moves to IDLE, sets align_err and pulses pkt_done.
    - Further SE0 strobes stay in EOP.
  - ERR: SE0 moves to EOP. Nothing further is emitted.
- Residual bits at SE0:
  - 0 or 1 leftover unstuffed bits: accepted (dribble bit).
  - 2 or more: set align_err.
- CRC:
  - Computed over unstuffed bits after the PID.
  - Token PIDs (pid[1:0] = 01): CRC5, polynomial 0x05; good residual 5'b01100.
  - Data PIDs (pid[1:0] = 11): CRC16, polynomial 0x8005; good residual 16'h800D.
  - Handshake PIDs (pid[1:0] = 10): no CRC check. byte_cnt != 0 sets len_err.
  - Special PIDs (pid[1:0] = 00) use token rules.
- SE0 while in IDLE/SYNC: silently returns to IDLE, with no pkt_done.
- Synchronous reset mid-packet: immediately to IDLE; no pkt_done; outputs cleared.
- Status outputs hold their values until the next pid_valid.
- pkt_done for a packet and SYNC start of the next packet cannot collide, because at least one J strobe separates them.

Optional Feature:
- USB_RX_CRC_EN defined:
  - CRC5/CRC16 logic is present and sets err_flags.crc.
- USB_RX_CRC_EN not defined:
  - No CRC logic.
  - err_flags.crc tied 0.
  - pkt_ok depends on the other four flags only.

Test Plan:
- Full SYNC then ACK (bytes D2), EOP SE0 SE0 J → pid = 8'hD2, pid_valid once, pkt_done, pkt_ok = 1, byte_cnt = 0, err_flags = 0.
- SETUP token, bytes 2D 00 10 with 3-zero truncated SYNC → pid = 8'h2D, out_data 00 then 10, byte_cnt = 2, crc = 0, pkt_ok = 1. Same packet with the last byte 11 → crc = 1, pkt_ok = 0.
- DATA0 packet C3 80 06 00 01 00 00 40 00 DD 94 → 10 out_valid pulses in order, byte_cnt = 10, pkt_ok = 1. Also DATA1 payload FF FF with correct stuffing → bytes FF FF restored, no stuff_err.
- Seven consecutive J-held bits (no stuff bit) inside a payload → stuff = 1, no further out_valid, pkt_done at EOP, pkt_ok = 0.
- PID byte C2 (check nibble mismatch) → pid_valid with 8'hC2, pid err = 1 at pkt_done. Separately, EOP after 3 extra bits → align = 1.
- rst asserted for one cycle after the 4th payload byte → busy = 0 next cycle, no pkt_done. Next clean ACK packet decodes correctly.

Source files
------------

// File: rtl/usb_rx_packet_if.sv
// usb_rx_packet_if
//   Bundles the sampled USB line state and the decoded packet stream of the
//   receive-side packet decoder.
//   master : line proxy / sniffer side (drives line samples, consumes results)
//   slave  : usb_rx_packet decoder
//   Line side   : bit_strobe, line_j, line_se0
//   Byte stream : out_data, out_valid, pid, pid_valid
//   Status      : pkt_done, pkt_ok, err_flags {len,align,crc,stuff,pid},
//                 byte_cnt, busy
interface usb_rx_packet_if;
  logic        bit_strobe;
  logic        line_j;
  logic        line_se0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [7:0]  pid;
  logic        pid_valid;
  logic        pkt_done;
  logic        pkt_ok;
  logic [4:0]  err_flags;
  logic [10:0] byte_cnt;
  logic        busy;

  modport master (
    output bit_strobe, line_j, line_se0,
    input  out_data, out_valid, pid, pid_valid,
    input  pkt_done, pkt_ok, err_flags, byte_cnt, busy
  );

  modport slave (
    input  bit_strobe, line_j, line_se0,
    output out_data, out_valid, pid, pid_valid,
    output pkt_done, pkt_ok, err_flags, byte_cnt, busy
  );
endinterface

// File: rtl/usb_rx_packet.sv
// usb_rx_packet
//   Receive-side USB packet decoder. One sampled line state (J/K/SE0) is
//   consumed per bit_strobe; performs SYNC detection, NRZI decode, bit
//   unstuffing, PID check, LSB-first byte assembly and CRC5/CRC16 check.
//   Emits the bytes after the PID plus a per-packet status pulse.
// Ports
//   clk, rst : system clock, synchronous active-high reset
//   bus      : usb_rx_packet_if.slave (line inputs, byte stream, status)
// Build option
//   USB_RX_CRC_EN : when defined, CRC5/CRC16 residual checking drives
//                   err_flags[2]; otherwise that flag is tied low.
module usb_rx_packet #(
  parameter int unsigned MAX_BYTES      = 1027,
  parameter int unsigned MIN_SYNC_ZEROS = 3
) (
  input  logic           clk,
  input  logic           rst,
  usb_rx_packet_if.slave bus
);

  localparam logic [10:0] MAX_CNT   = 11'(MAX_BYTES);
  localparam logic [4:0]  MIN_ZEROS = 5'(MIN_SYNC_ZEROS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_EOP,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        prev_j_q, prev_j_d;
  logic [4:0]  zeros_q, zeros_d;
  logic [2:0]  ones_q, ones_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [10:0] cnt_q, cnt_d;
  logic        e_len_q, e_len_d;
  logic        e_align_q, e_align_d;
  logic        e_stuff_q, e_stuff_d;
  logic        e_pid_q, e_pid_d;

  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  pid_q, pid_d;
  logic        pid_valid_q, pid_valid_d;
  logic        pkt_done_q, pkt_done_d;
  logic        pkt_ok_q, pkt_ok_d;
  logic [4:0]  err_flags_q, err_flags_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        busy_q, busy_d;

  logic        crc_flag;

`ifdef USB_RX_CRC_EN
  localparam logic [4:0]  CRC5_GOOD  = 5'b01100;
  localparam logic [15:0] CRC16_GOOD = 16'h800D;

  logic        e_crc_q, e_crc_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;

  // Bits enter in wire order (byte LSB first) into an MSB-first shifter.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (d[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'h05;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_flag = e_crc_q;
`else
  assign crc_flag = 1'b0;
`endif

  logic       dec_bit;
  logic [7:0] new_byte;

  assign dec_bit  = (bus.line_j == prev_j_q);
  assign new_byte = {dec_bit, shift_q[7:1]};

  always_comb begin
    state_d     = state_q;
    prev_j_d    = prev_j_q;
    zeros_d     = zeros_q;
    ones_d      = ones_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    e_len_d     = e_len_q;
    e_align_d   = e_align_q;
    e_stuff_d   = e_stuff_q;
    e_pid_d     = e_pid_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    pid_d       = pid_q;
    pid_valid_d = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = pkt_ok_q;
    err_flags_d = err_flags_q;
    byte_cnt_d  = byte_cnt_q;
`ifdef USB_RX_CRC_EN
    e_crc_d     = e_crc_q;
    crc5_d      = crc5_q;
    crc16_d     = crc16_q;
`endif

    if (bus.bit_strobe) begin
      if (!bus.line_se0) prev_j_d = bus.line_j;

      case (state_q)
        S_IDLE: begin
          if (!bus.line_se0 && !bus.line_j) begin
            state_d = S_SYNC;
            zeros_d = 5'd1;
          end
        end

        S_SYNC: begin
          if (bus.line_se0) begin
            state_d = S_IDLE;
          end else if (!dec_bit) begin
            if (zeros_q != '1) zeros_d = zeros_q + 5'd1;
          end else if (zeros_q >= MIN_ZEROS) begin
            state_d   = S_PID;
            ones_d    = '0;
            bit_cnt_d = '0;
            cnt_d     = '0;
            e_len_d   = 1'b0;
            e_align_d = 1'b0;
            e_stuff_d = 1'b0;
            e_pid_d   = 1'b0;
`ifdef USB_RX_CRC_EN
            e_crc_d   = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end

        S_PID, S_DATA: begin
          if (bus.line_se0) begin
            state_d = S_EOP;
            // One leftover bit is a tolerated dribble bit.
            if (bit_cnt_q >= 3'd2) e_align_d = 1'b1;
            if (state_q == S_DATA) begin
              if (pid_q[1:0] == 2'b10 && cnt_q != '0) e_len_d = 1'b1;
`ifdef USB_RX_CRC_EN
              if (pid_q[1:0] == 2'b11)      e_crc_d = (crc16_q != CRC16_GOOD);
              else if (pid_q[1:0] != 2'b10) e_crc_d = (crc5_q != CRC5_GOOD);
`endif
            end
          end else if (ones_q == 3'd6) begin
            // Stuff slot: a 0 is dropped, a 1 is a stuffing violation.
            if (dec_bit) begin
              e_stuff_d = 1'b1;
              state_d   = S_ERR;
            end else begin
              ones_d = '0;
            end
          end else begin
            ones_d    = dec_bit ? ones_q + 3'd1 : 3'd0;
            shift_d   = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == S_PID) begin
                state_d     = S_DATA;
                pid_d       = new_byte;
                pid_valid_d = 1'b1;
                e_pid_d     = (new_byte[3:0] != ~new_byte[7:4]);
                pkt_ok_d    = 1'b0;
                err_flags_d = '0;
                byte_cnt_d  = '0;
`ifdef USB_RX_CRC_EN
                crc5_d      = '1;
                crc16_d     = '1;
`endif
              end else if (cnt_q == MAX_CNT) begin
                e_len_d = 1'b1;
              end else begin
                out_data_d  = new_byte;
                out_valid_d = 1'b1;
                cnt_d       = cnt_q + 11'd1;
`ifdef USB_RX_CRC_EN
                crc5_d      = crc5_byte(crc5_q, new_byte);
                crc16_d     = crc16_byte(crc16_q, new_byte);
`endif
              end
            end
          end
        end

        S_EOP: begin
          if (!bus.line_se0) begin
            state_d     = S_IDLE;
            pkt_done_d  = 1'b1;
            err_flags_d = {e_len_q, e_align_q | ~bus.line_j, crc_flag, e_stuff_q, e_pid_q};
            pkt_ok_d    = ~(e_len_q | e_align_q | ~bus.line_j | crc_flag | e_stuff_q | e_pid_q);
            byte_cnt_d  = cnt_q;
          end
        end

        S_ERR: begin
          if (bus.line_se0) state_d = S_EOP;
        end

        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prev_j_q    <= 1'b1;
      zeros_q     <= '0;
      ones_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      e_len_q     <= 1'b0;
      e_align_q   <= 1'b0;
      e_stuff_q   <= 1'b0;
      e_pid_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pid_q       <= '0;
      pid_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      err_flags_q <= '0;
      byte_cnt_q  <= '0;
      busy_q      <= 1'b0;
`ifdef USB_RX_CRC_EN
      e_crc_q     <= 1'b0;
      crc5_q      <= '1;
      crc16_q     <= '1;
`endif
    end else begin
      state_q     <= state_d;
      prev_j_q    <= prev_j_d;
      zeros_q     <= zeros_d;
      ones_q      <= ones_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      e_len_q     <= e_len_d;
      e_align_q   <= e_align_d;
      e_stuff_q   <= e_stuff_d;
      e_pid_q     <= e_pid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pid_q       <= pid_d;
      pid_valid_q <= pid_valid_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
      err_flags_q <= err_flags_d;
      byte_cnt_q  <= byte_cnt_d;
      busy_q      <= busy_d;
`ifdef USB_RX_CRC_EN
      e_crc_q     <= e_crc_d;
      crc5_q      <= crc5_d;
      crc16_q     <= crc16_d;
`endif
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pid       = pid_q;
  assign bus.pid_valid = pid_valid_q;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.pkt_ok    = pkt_ok_q;
  assign bus.err_flags = err_flags_q;
  assign bus.byte_cnt  = byte_cnt_q;
  assign bus.busy      = busy_q;

endmodule
